// File: rtl/mem_bank_atomic_adapter.sv
// Bank-port adapter: request/grant/rvalid with AXI ATOPs onto a single-port SRAM
// with fixed read latency. Atomics run as a locked read-modify-write that returns
// the old value.
module mem_bank_atomic_adapter #(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned SramLatency = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   busy_o,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] strb_i,
  input  logic [5:0]             atop_i,
  input  logic                   we_i,
  output logic                   rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   sram_req_o,
  output logic                   sram_we_o,
  output logic [AddrWidth-1:0]   sram_addr_o,
  output logic [DataWidth-1:0]   sram_wdata_o,
  output logic [DataWidth/8-1:0] sram_be_o,
  input  logic [DataWidth-1:0]   sram_rdata_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam logic [5:0]  AtopSwap  = 6'b110000;

  typedef enum logic [1:0] {StIdle, StAmoWait, StAmoWrite} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   operand_q;
  logic [StrbWidth-1:0]   strb_q;
  logic [5:0]             atop_q;
  logic [DataWidth-1:0]   result_q, result_d;
  logic [SramLatency-1:0] pipe_valid_q, pipe_amo_q;

  logic hs, is_amo, amo_done, amo_supported;

  assign is_amo   = we_i & (atop_i[5:4] != 2'b00);
  // Grant is withheld while reset is held so nothing can be accepted.
  assign gnt_o    = (state_q == StIdle) & ~rst_i;
  assign hs       = req_i & gnt_o;
  assign amo_done = pipe_valid_q[SramLatency-1] & pipe_amo_q[SramLatency-1];
  // Compare and big-endian variants are not executed; they degrade to a plain read.
  assign amo_supported = (((atop_q[5:4] == 2'b01) || (atop_q[5:4] == 2'b10)) && !atop_q[3])
                         || (atop_q == AtopSwap);

  assign rvalid_o = pipe_valid_q[SramLatency-1];
  assign rdata_o  = sram_rdata_i;
  assign busy_o   = (state_q != StIdle) | (|pipe_valid_q);

  // Atomic ALU over the old memory word and the captured operand.
  always_comb begin
    result_d = sram_rdata_i;
    if (atop_q == AtopSwap) begin
      result_d = operand_q;
    end else begin
      unique case (atop_q[2:0])
        3'b000: result_d = sram_rdata_i + operand_q;
        3'b001: result_d = sram_rdata_i & ~operand_q;
        3'b010: result_d = sram_rdata_i ^ operand_q;
        3'b011: result_d = sram_rdata_i | operand_q;
        3'b100: result_d = ($signed(sram_rdata_i) > $signed(operand_q)) ? sram_rdata_i : operand_q;
        3'b101: result_d = ($signed(sram_rdata_i) < $signed(operand_q)) ? sram_rdata_i : operand_q;
        3'b110: result_d = (sram_rdata_i > operand_q) ? sram_rdata_i : operand_q;
        3'b111: result_d = (sram_rdata_i < operand_q) ? sram_rdata_i : operand_q;
        default: result_d = sram_rdata_i;
      endcase
    end
  end

  // Next-state and SRAM command decode.
  always_comb begin
    state_d      = state_q;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = addr_i;
    sram_wdata_o = wdata_i;
    sram_be_o    = strb_i;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          sram_req_o = 1'b1;
          sram_we_o  = we_i & ~is_amo;
          if (is_amo) state_d = StAmoWait;
        end
      end
      StAmoWait: begin
        if (amo_done) begin
          state_d = (amo_supported && (strb_q != '0)) ? StAmoWrite : StIdle;
        end
      end
      StAmoWrite: begin
        sram_req_o   = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = addr_q;
        sram_wdata_o = result_q;
        sram_be_o    = strb_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and response pipeline; reset drops everything in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      pipe_valid_q <= '0;
      pipe_amo_q   <= '0;
    end else begin
      state_q         <= state_d;
      pipe_valid_q[0] <= hs;
      pipe_amo_q[0]   <= hs & is_amo;
      for (int i = 1; i < int'(SramLatency); i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_amo_q[i]   <= pipe_amo_q[i-1];
      end
    end
  end

  // Atomic context: captured at acceptance, result latched when the old value returns.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      operand_q <= '0;
      strb_q    <= '0;
      atop_q    <= '0;
      result_q  <= '0;
    end else begin
      if (hs && is_amo) begin
        addr_q    <= addr_i;
        operand_q <= wdata_i;
        strb_q    <= strb_i;
        atop_q    <= atop_i;
      end
      if ((state_q == StAmoWait) && amo_done) result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mem_bank_atomic_adapter.sv
// Scoreboard bench: dut1 (latency 1) carries the functional traffic against an SRAM
// model; dut2 (latency 3) is used for the reset-during-atomic scenario.
module tb_mem_bank_atomic_adapter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut1 signals
  logic        req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic [3:0]  strb1 = '0;
  logic [5:0]  atop1 = '0;
  logic        gnt1, busy1, rvalid1, s_req1, s_we1;
  logic [31:0] rdata1, s_addr1, s_wdata1, s_rdata1;
  logic [3:0]  s_be1;

  // dut2 signals
  logic        req2 = 1'b0, we2 = 1'b0;
  logic [31:0] addr2 = '0, wdata2 = '0;
  logic [3:0]  strb2 = '0;
  logic [5:0]  atop2 = '0;
  logic        gnt2, busy2, rvalid2, s_req2, s_we2;
  logic [31:0] rdata2, s_addr2, s_wdata2, s_rdata2;
  logic [3:0]  s_be2;

  mem_bank_atomic_adapter #(.AddrWidth(32), .DataWidth(32), .SramLatency(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .busy_o(busy1), .req_i(req1), .gnt_o(gnt1),
    .addr_i(addr1), .wdata_i(wdata1), .strb_i(strb1), .atop_i(atop1), .we_i(we1),
    .rvalid_o(rvalid1), .rdata_o(rdata1), .sram_req_o(s_req1), .sram_we_o(s_we1),
    .sram_addr_o(s_addr1), .sram_wdata_o(s_wdata1), .sram_be_o(s_be1),
    .sram_rdata_i(s_rdata1)
  );

  mem_bank_atomic_adapter #(.AddrWidth(32), .DataWidth(32), .SramLatency(3)) dut2 (
    .clk_i(clk), .rst_i(rst), .busy_o(busy2), .req_i(req2), .gnt_o(gnt2),
    .addr_i(addr2), .wdata_i(wdata2), .strb_i(strb2), .atop_i(atop2), .we_i(we2),
    .rvalid_o(rvalid2), .rdata_o(rdata2), .sram_req_o(s_req2), .sram_we_o(s_we2),
    .sram_addr_o(s_addr2), .sram_wdata_o(s_wdata2), .sram_be_o(s_be2),
    .sram_rdata_i(s_rdata2)
  );

  // SRAM model for dut1, one cycle read latency, byte-enabled writes.
  logic [31:0] mem1 [256];
  always @(posedge clk) begin
    if (s_req1) begin
      if (s_we1) begin
        for (int b = 0; b < 4; b++)
          if (s_be1[b]) mem1[s_addr1[9:2]][8*b +: 8] <= s_wdata1[8*b +: 8];
      end
      s_rdata1 <= mem1[s_addr1[9:2]];
    end
  end

  assign s_rdata2 = 32'hCAFEF00D;

  typedef struct {
    bit          chk;
    logic [31:0] data;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [256];
  int          n_vec = 0, n_err = 0;
  int          wr1 = 0, wr2 = 0, rv2 = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Reference memory image after an atomic.
  function automatic logic [31:0] amo_ref(input logic [5:0] at, input logic [31:0] old,
                                          input logic [31:0] op, input logic [3:0] be);
    logic [31:0] r;
    bit sup;
    sup = ((at[5:4] == 2'b01 || at[5:4] == 2'b10) && !at[3]) || (at == 6'b110000);
    if (!sup || be == 4'h0) return old;
    if (at == 6'b110000) r = op;
    else begin
      case (at[2:0])
        3'd0: r = old + op;
        3'd1: r = old & ~op;
        3'd2: r = old ^ op;
        3'd3: r = old | op;
        3'd4: r = ($signed(old) >= $signed(op)) ? old : op;
        3'd5: r = ($signed(old) <= $signed(op)) ? old : op;
        3'd6: r = (old >= op) ? old : op;
        default: r = (old <= op) ? old : op;
      endcase
    end
    return merge(old, r, be);
  endfunction

  // Monitors sample on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (s_req1 && s_we1) wr1++;
    if (rvalid1) begin
      check_eq("rvalid1_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq({e.tag, "_lat"}, 32'(cyc), 32'(e.cyc + 1));
        if (e.chk) check_eq(e.tag, rdata1, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (rvalid2) rv2++;
    if (s_req2 && s_we2) wr2++;
  end

  // Issue one request on dut1 (called at a falling edge, returns one falling edge
  // after the handshake).
  task automatic send(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sb,
                      input logic [5:0] at, input logic w, input string tag);
    exp_t e;
    int   n = 0;
    logic [7:0] idx;
    addr1 = a; wdata1 = wd; strb1 = sb; atop1 = at; we1 = w; req1 = 1'b1;
    while (!gnt1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!gnt1) begin
      check_eq({tag, "_gnt_timeout"}, 32'(gnt1), 32'd1);
      req1 = 1'b0;
      return;
    end
    idx   = a[9:2];
    e.cyc = cyc;
    e.tag = tag;
    e.chk = 1'b1;
    if (w && at[5:4] != 2'b00) begin
      e.data       = ref_mem[idx];
      ref_mem[idx] = amo_ref(at, ref_mem[idx], wd, sb);
    end else if (w) begin
      e.chk        = 1'b0;
      e.data       = '0;
      ref_mem[idx] = merge(ref_mem[idx], wd, sb);
    end else begin
      e.data = ref_mem[idx];
    end
    exp_q.push_back(e);
    @(negedge clk);
    req1 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int          w0, r0;
    logic [31:0] old, opnd;
    logic [2:0]  op;
    foreach (ref_mem[i]) ref_mem[i] = '0;

    // Reset: grant and SRAM request stay low even with a request pending.
    rst  = 1'b1;
    req1 = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_gnt", 32'(gnt1), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid1), 32'd0);
    check_eq("rst_sram_req", 32'(s_req1), 32'd0);
    check_eq("rst_busy", 32'(busy1), 32'd0);
    req1 = 1'b0;
    rst  = 1'b0;
    @(negedge clk);
    check_eq("post_rst_gnt", 32'(gnt1), 32'd1);

    // Back-to-back write then read.
    send(32'h10, 32'hDEADBEEF, 4'hF, 6'b000000, 1'b1, "wr10");
    send(32'h10, 32'h0, 4'hF, 6'b000000, 1'b0, "rd10");
    drain();

    // ATOMICLOAD ADD: old value back, grant low two cycles, write of the sum.
    send(32'h20, 32'd5, 4'hF, 6'b000000, 1'b1, "wr20");
    drain();
    send(32'h20, 32'd3, 4'hF, 6'b100000, 1'b1, "ldadd");
    check_eq("ldadd_gnt_t1", 32'(gnt1), 32'd0);
    @(negedge clk);
    check_eq("ldadd_gnt_t2", 32'(gnt1), 32'd0);
    check_eq("ldadd_wr_cmd", 32'({s_req1, s_we1}), 32'd3);
    check_eq("ldadd_wr_addr", s_addr1, 32'h20);
    check_eq("ldadd_wr_data", s_wdata1, 32'd8);
    @(negedge clk);
    check_eq("ldadd_gnt_t3", 32'(gnt1), 32'd1);
    send(32'h20, 32'h0, 4'hF, 6'b000000, 1'b0, "rd20");
    drain();
    check_eq("ldadd_mem", mem1[8], 32'd8);

    // Wrap-around add, signed and unsigned max.
    send(32'h20, 32'hFFFFFFFF, 4'hF, 6'b000000, 1'b1, "wr20b");
    send(32'h20, 32'd1, 4'hF, 6'b010000, 1'b1, "stadd");
    send(32'h24, 32'h80000000, 4'hF, 6'b000000, 1'b1, "wr24");
    send(32'h24, 32'd1, 4'hF, 6'b010100, 1'b1, "smax");
    send(32'h28, 32'h80000000, 4'hF, 6'b000000, 1'b1, "wr28");
    send(32'h28, 32'd1, 4'hF, 6'b010110, 1'b1, "umax");
    drain();
    @(negedge clk);
    check_eq("stadd_mem", mem1[8], 32'h0);
    check_eq("smax_mem", mem1[9], 32'h1);
    check_eq("umax_mem", mem1[10], 32'h80000000);

    // Partial-strobe swap.
    send(32'h2C, 32'h12345678, 4'hF, 6'b000000, 1'b1, "wr2c");
    send(32'h2C, 32'hA5A5A5A5, 4'b0011, 6'b110000, 1'b1, "swap");
    drain();
    @(negedge clk);
    check_eq("swap_mem", mem1[11], 32'h1234A5A5);

    // Every ALU op on random data, read back after each.
    for (int k = 0; k < 8; k++) begin
      op   = 3'(k);
      old  = $urandom;
      opnd = $urandom;
      send(32'h40, old, 4'hF, 6'b000000, 1'b1, "wr40");
      send(32'h40, opnd, 4'hF, {3'b010, op}, 1'b1, "aluop");
      send(32'h40, 32'h0, 4'hF, 6'b000000, 1'b0, "rd40");
    end
    drain();

    // Unsupported and zero-strobe atomics: old value, no write.
    send(32'h30, 32'h11223344, 4'hF, 6'b000000, 1'b1, "wr30");
    drain();
    w0 = wr1;
    send(32'h30, 32'hFFFFFFFF, 4'hF, 6'b101000, 1'b1, "be_amo");
    send(32'h30, 32'hFFFFFFFF, 4'h0, 6'b100000, 1'b1, "strb0_amo");
    send(32'h30, 32'hFFFFFFFF, 4'hF, 6'b110001, 1'b1, "cmp_amo");
    drain();
    repeat (2) @(negedge clk);
    check_eq("noamo_writes", 32'(wr1), 32'(w0));
    check_eq("noamo_mem", mem1[12], 32'h11223344);

    // Reset while dut2 (latency 3) waits on an atomic read.
    addr2 = 32'h50; wdata2 = 32'd1; strb2 = 4'hF; atop2 = 6'b100000; we2 = 1'b1;
    req2  = 1'b1;
    check_eq("d2_gnt", 32'(gnt2), 32'd1);
    @(negedge clk);
    req2 = 1'b0;
    check_eq("d2_wait_gnt", 32'(gnt2), 32'd0);
    check_eq("d2_wait_busy", 32'(busy2), 32'd1);
    r0  = rv2;
    w0  = wr2;
    rst = 1'b1;
    @(negedge clk);
    check_eq("d2_rst_gnt", 32'(gnt2), 32'd0);
    check_eq("d2_rst_busy", 32'(busy2), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("d2_gnt_after", 32'(gnt2), 32'd1);
    check_eq("d2_busy_after", 32'(busy2), 32'd0);
    repeat (6) @(negedge clk);
    check_eq("d2_no_rvalid", 32'(rv2), 32'(r0));
    check_eq("d2_no_write", 32'(wr2), 32'(w0));
    check_eq("d2_idle_gnt", 32'(gnt2), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_bank_atomic_adapter.md
Name: mem_bank_atomic_adapter

Overview:
- Per-bank stage directly downstream of the interleaved AXI-to-memory converter, one instance per bank port.
- Converts the bank request/grant/rvalid protocol, including the atop field, into accesses on a plain single-port SRAM macro with fixed read latency.
- Non-atomic reads and writes pass through at one per cycle.
- AXI ATOPs execute as a locked read-modify-write; the old memory value is returned as the response.

Parameters:
- AddrWidth, 32, width of the bank address (byte address, passed through unchanged).
- DataWidth, 32, bank word width; multiple of 8.
- SramLatency, 1, cycles from SRAM request to valid sram_rdata_i; must be >= 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- busy_o  out  1  high if any response is outstanding or an atomic is in progress.
- req_i  in  1  request valid from upstream.
- gnt_o  out  1  request accepted this cycle (handshake is req_i & gnt_o).
- addr_i  in  AddrWidth  request address.
- wdata_i  in  DataWidth  write data / atomic operand.
- strb_i  in  DataWidth/8  byte enables.
- atop_i  in  6  AXI ATOP encoding.
- we_i  in  1  write enable.
- rvalid_o  out  1  one pulse per accepted request, in acceptance order; no backpressure.
- rdata_o  out  DataWidth  response data; old value for atomics.
- sram_req_o  out  1  SRAM access enable.
- sram_we_o  out  1  SRAM write.
- sram_addr_o  out  AddrWidth  SRAM address.
- sram_wdata_o  out  DataWidth  SRAM write data.
- sram_be_o  out  DataWidth/8  SRAM byte enables.
- sram_rdata_i  in  DataWidth  SRAM read data, valid SramLatency cycles after the request.

Behaviour:
- Reset values: FSM=IDLE; response pipeline cleared; rvalid_o=0, sram_req_o=0, busy_o=0, gnt_o=0 while rst_i is asserted.
- Reset mid-operation drops in-flight responses and any pending atomic write.
- Atomic classification: atop_i[5:4] != 2'b00 and we_i=1.
- Supported atomics:
  - ATOMICSTORE (01) and ATOMICLOAD (10) with little-endian op (atop_i[3]=0).
  - ATOMICSWAP (6'b110000).
- Unsupported atomics (ATOMICCOMPARE, big-endian bit set) run as a plain read: no write, old data returned.
- FSM states: IDLE, AMO_WAIT, AMO_WRITE.
- IDLE:
  - gnt_o=1.
  - On handshake, drive sram_req_o=1, sram_addr_o=addr_i, sram_be_o=strb_i in the same cycle.
  - Plain request: sram_we_o=we_i, sram_wdata_o=wdata_i.
  - Atomic request: sram_we_o=0. Capture addr, operand, strb and atop into registers; go to AMO_WAIT.
- Response pipeline: a SramLatency-deep shift register of {valid, is_amo} is pushed on every handshake. At its output, rvalid_o=valid and rdata_o=sram_rdata_i. This applies to writes too; rdata for writes is don't-care.
- AMO_WAIT:
  - gnt_o=0.
  - When the pipeline output carries is_amo=1: rvalid_o pulses with the old value; compute result = f(old, operand).
  - If captured strb != 0, go to AMO_WRITE; otherwise go to IDLE.
- AMO_WRITE:
  - gnt_o=0.
  - Drive sram_req_o=1, sram_we_o=1, sram_addr_o=captured addr, sram_wdata_o=result, sram_be_o=captured strb.
  - No response is generated; next state IDLE.
- Operation f, over the full DataWidth word:
  - ADD: old+op, modulo 2^DataWidth.
  - CLR: old&~op.
  - EOR: old^op.
  - SET: old|op.
  - SMAX / SMIN: two's-complement compare.
  - UMAX / UMIN: unsigned compare.
  - SWAP: op.
- Requests accepted before an atomic complete in order ahead of it; no request is accepted until the atomic write is issued.
- Timing:
  - Plain latency: handshake cycle T to rvalid_o at T+SramLatency; throughput 1/cycle.
  - Atomic: response at T+SramLatency, write at T+SramLatency+1; gnt_o low for SramLatency+1 cycles.
- sram_req_o=0 in IDLE without a handshake and in AMO_WAIT.
- busy_o = (FSM != IDLE) | any pipeline valid.

Test Plan:
- Reset then back-to-back: write 0xDEADBEEF @0x10, then read @0x10 next cycle (SramLatency=1) -> two rvalid pulses at T+1 and T+2; second rdata=0xDEADBEEF.
- mem[0x20]=5; ATOMICLOAD ADD operand 3, strb=4'hF -> rdata=5; gnt_o low for 2 cycles; subsequent read returns 8.
- mem[0x20]=0xFFFFFFFF; ATOMICSTORE ADD operand 1 -> wraps to 0; SMAX operand 0x00000001 on 0x80000000 -> stored 1; UMAX same -> stored 0x80000000.
- ATOMICSWAP operand 0xA5A5A5A5 with strb=4'b0011 on mem=0x12345678 -> rdata=0x12345678; memory becomes 0x1234A5A5.
- Big-endian atomic (atop=6'b101000) and strb=0 atomic -> old value returned; no SRAM write cycle; memory unchanged.
- Assert rst_i during AMO_WAIT (SramLatency=3) -> no rvalid_o, no SRAM write, busy_o=0, gnt_o=1 one cycle after release.
